// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg
// Shared types and address-field constants for the direct-mapped L1 data
// cache controller (dcache_ctrl) and its storage array (dcache_sram).
//   state_e   : controller FSM states
//   TAG_W     : tag width at the default 5-bit index
//   OFFSET_W  : byte-offset bits within a 16-byte line
//   LINE_W    : line width in bits
// ---------------------------------------------------------------------------
package dcache_pkg;

  localparam int ADDR_W      = 32;
  localparam int WORD_W      = 32;
  localparam int OFFSET_W    = 4;
  localparam int LINE_W      = 128;
  localparam int WSEL_W      = 2;
  localparam int DEF_INDEX_W = 5;

  // Field extraction: word select sits above the ignored byte bits, the
  // index sits directly above the line offset, the tag takes the rest.
  localparam int WORD_LSB  = 2;
  localparam int INDEX_LSB = OFFSET_W;
  localparam int TAG_W     = ADDR_W - OFFSET_W - DEF_INDEX_W;

  function automatic int tag_width(input int index_w);
    return ADDR_W - OFFSET_W - index_w;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_ALLOCATE,
    ST_REFILL
  } state_e;

endpackage

// File: rtl/dcache_sram.sv
// ---------------------------------------------------------------------------
// dcache_sram
// Tag/valid/dirty/data storage for the direct-mapped cache.
// Combinational read at index_i, synchronous write.
//   clk_i, rst_i   : clock, synchronous active-high reset (clears valid/dirty)
//   index_i        : line index for both read and write
//   line_we_i      : write whole line (tag_i, line_i), valid=1, dirty=0
//   word_we_i      : write one word (word_sel_i, word_i), dirty=1
//   valid_o, dirty_o, tag_o, line_o : contents of the indexed line
// ---------------------------------------------------------------------------
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int TW      = tag_width(INDEX_W)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] index_i,
  input  logic               line_we_i,
  input  logic [TW-1:0]      tag_i,
  input  logic [LINE_W-1:0]  line_i,
  input  logic               word_we_i,
  input  logic [WSEL_W-1:0]  word_sel_i,
  input  logic [WORD_W-1:0]  word_i,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [TW-1:0]      tag_o,
  output logic [LINE_W-1:0]  line_o
);

  localparam int LINES = 2 ** INDEX_W;

  logic [LINES-1:0]  valid_q;
  logic [LINES-1:0]  dirty_q;
  logic [TW-1:0]     tag_q  [LINES];
  logic [LINE_W-1:0] data_q [LINES];

  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];
  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (line_we_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; a cleared valid
  // bit already makes their contents unobservable.
  always_ff @(posedge clk_i) begin
    if (line_we_i) begin
      tag_q[index_i]  <= tag_i;
      data_q[index_i] <= line_i;
    end else if (word_we_i) begin
      data_q[index_i][word_sel_i*WORD_W +: WORD_W] <= word_i;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// ---------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate L1 data cache controller between
// the EX/MEM stage and a line-wide backing memory. Hits complete in the same
// cycle; misses hold stall_o until writeback (if dirty), refill and the
// re-evaluated hit complete.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   addr_i, data_i        : CPU byte address and store data
//   MemRead_i, MemWrite_i : load / store request (both high = store)
//   data_o, stall_o       : load data, pipeline freeze
//   mem_*                 : backing-memory request (level), line address,
//                           writeback line, refill line, one-cycle ack
// Optional macro DCACHE_STATS_EN adds saturating hit_cnt_o / miss_cnt_o.
// ---------------------------------------------------------------------------
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int INDEX_W = 5,
  parameter int MEM_AW  = 28
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        data_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  output logic [31:0]        data_o,
  output logic               stall_o,
  output logic [MEM_AW-1:0]  mem_addr_o,
  output logic [LINE_W-1:0]  mem_data_o,
  output logic               mem_enable_o,
  output logic               mem_write_o,
  input  logic [LINE_W-1:0]  mem_data_i,
  input  logic               mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]        hit_cnt_o,
  output logic [31:0]        miss_cnt_o
`endif
);

  localparam int TW = tag_width(INDEX_W);

  state_e              state_q, state_d;
  logic                mem_enable_q, mem_enable_d;
  logic                mem_write_q, mem_write_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0]   mem_data_q, mem_data_d;
  logic [LINE_W-1:0]   refill_q, refill_d;

  logic [INDEX_W-1:0]  index;
  logic [TW-1:0]       tag;
  logic [WSEL_W-1:0]   word_sel;
  logic                req, hit;
  logic                rd_valid, rd_dirty;
  logic [TW-1:0]       rd_tag;
  logic [LINE_W-1:0]   rd_line;
  logic [WORD_W-1:0]   rd_word;
  logic                line_we, word_we;
  logic                unused_byte_bits;

  assign index            = addr_i[INDEX_LSB +: INDEX_W];
  assign tag              = addr_i[ADDR_W-1 -: TW];
  assign word_sel         = addr_i[WORD_LSB +: WSEL_W];
  assign unused_byte_bits = ^addr_i[1:0];

  assign req     = MemRead_i | MemWrite_i;
  assign hit     = rd_valid && (rd_tag == tag);
  assign rd_word = rd_line[word_sel*WORD_W +: WORD_W];

  dcache_sram #(.INDEX_W(INDEX_W), .TW(TW)) u_sram (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .index_i    (index),
    .line_we_i  (line_we),
    .tag_i      (tag),
    .line_i     (refill_q),
    .word_we_i  (word_we),
    .word_sel_i (word_sel),
    .word_i     (data_i),
    .valid_o    (rd_valid),
    .dirty_o    (rd_dirty),
    .tag_o      (rd_tag),
    .line_o     (rd_line)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      refill_q     <= '0;
    end else begin
      state_q      <= state_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      refill_q     <= refill_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    line_we      = 1'b0;
    word_we      = 1'b0;
    mem_enable_d = 1'b0;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    refill_d     = refill_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          if (hit) begin
            word_we = MemWrite_i;
          end else begin
            stall_o = 1'b1;
            state_d = (rd_valid && rd_dirty) ? ST_WRITEBACK : ST_ALLOCATE;
          end
        end
      end
      ST_WRITEBACK: begin
        // Enable drops in the cycle after the ack, so ALLOCATE starts low.
        stall_o      = 1'b1;
        mem_enable_d = !mem_ack_i;
        mem_write_d  = 1'b1;
        mem_addr_d   = {rd_tag, index};
        mem_data_d   = rd_line;
        if (mem_ack_i) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        stall_o      = 1'b1;
        mem_enable_d = !mem_ack_i;
        mem_write_d  = 1'b0;
        mem_addr_d   = addr_i[ADDR_W-1:OFFSET_W];
        if (mem_ack_i) begin
          refill_d = mem_data_i;
          state_d  = ST_REFILL;
        end
      end
      ST_REFILL: begin
        stall_o = 1'b1;
        line_we = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign data_o       = (state_q == ST_IDLE && MemRead_i && hit) ? rd_word : '0;
  assign mem_enable_o = mem_enable_q;
  assign mem_write_o  = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

`ifdef DCACHE_STATS_EN
  // The hit that completes a just-refilled miss belongs to that miss and is
  // not counted again; retry_q marks that one cycle.
  logic        retry_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      retry_q    <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      retry_q <= (state_q == ST_REFILL);
      if (state_q == ST_IDLE && req) begin
        if (hit && !retry_q && hit_cnt_q != 32'hFFFF_FFFF)
          hit_cnt_q <= hit_cnt_q + 32'd1;
        if (!hit && miss_cnt_q != 32'hFFFF_FFFF)
          miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl
// Directed test-plan sequence followed by random accesses, checked against a
// behavioural cache/memory model (arrays of lines plus a sparse backing
// memory). A responder process plays the slow memory with a programmable
// latency and logs every request it acknowledges.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl;

  typedef struct {
    bit           wr;
    logic [27:0]  addr;
    logic [127:0] data;
  } txn_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr, wdata;
  logic         mem_read, mem_write;
  logic [31:0]  data_o;
  logic         stall_o;
  logic [27:0]  mem_addr_o;
  logic [127:0] mem_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [127:0] mem_rdata;
  logic         resp_ack, man_ack;
  wire          mem_ack = resp_ack | man_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .addr_i       (addr),
    .data_i       (wdata),
    .MemRead_i    (mem_read),
    .MemWrite_i   (mem_write),
    .data_o       (data_o),
    .stall_o      (stall_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_rdata),
    .mem_ack_i    (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_cnt_o    (hit_cnt_o),
    .miss_cnt_o   (miss_cnt_o)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [127:0] mem [logic [27:0]];
  bit           m_valid [32];
  bit           m_dirty [32];
  logic [22:0]  m_tag   [32];
  logic [127:0] m_line  [32];
  int           m_hits = 0, m_misses = 0;

  function automatic logic [127:0] mem_line(input logic [27:0] la);
    if (!mem.exists(la)) mem[la] = {$urandom, $urandom, $urandom, $urandom};
    return mem[la];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
    end
    m_hits   = 0;
    m_misses = 0;
  endfunction

  // ---------------- memory responder ----------------
  bit   resp_on = 1;
  int   latency = 3;
  int   en_cnt  = 0;
  txn_t traffic[$];

  initial begin
    resp_ack  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      resp_ack = 1'b0;
      if (resp_on && mem_enable_o && !rst) begin
        en_cnt++;
        if (en_cnt >= latency) begin
          resp_ack = 1'b1;
          en_cnt   = 0;
          if (mem_write_o) begin
            traffic.push_back('{wr: 1'b1, addr: mem_addr_o, data: mem_data_o});
          end else begin
            mem_rdata = mem_line(mem_addr_o);
            traffic.push_back('{wr: 1'b0, addr: mem_addr_o, data: '0});
          end
        end
      end else begin
        en_cnt = 0;
      end
    end
  end

  // One access, entered at posedge+1 and left at posedge+1 of the cycle
  // after completion. Checks stall_o every cycle, read data, and traffic.
  task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                        input logic [31:0] wd, input int lat,
                        output int n_stall, output logic [31:0] rdata);
    logic [4:0]  idx;
    logic [22:0] tg;
    int          w, exp_stall, guard;
    bit          req, exp_hit, exp_wb;
    logic [31:0] exp_data;
    txn_t        exp_q[$];

    idx     = a[8:4];
    tg      = a[31:9];
    w       = int'(a[3:2]);
    req     = rd | wr;
    exp_hit = m_valid[idx] && (m_tag[idx] == tg);
    exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
    exp_stall = (!req || exp_hit) ? 0 : (exp_wb ? 2 * lat + 4 : lat + 3);

    if (req) begin
      if (exp_hit) m_hits++;
      else m_misses++;
      if (!exp_hit) begin
        if (exp_wb) begin
          exp_q.push_back('{wr: 1'b1, addr: {m_tag[idx], idx}, data: m_line[idx]});
          mem[{m_tag[idx], idx}] = m_line[idx];
        end
        exp_q.push_back('{wr: 1'b0, addr: a[31:4], data: '0});
        m_line[idx]  = mem_line(a[31:4]);
        m_tag[idx]   = tg;
        m_valid[idx] = 1;
        m_dirty[idx] = 0;
      end
      if (wr) begin
        m_line[idx][w*32 +: 32] = wd;
        m_dirty[idx] = 1;
      end
    end
    exp_data = m_line[idx][w*32 +: 32];

    latency = lat;
    traffic.delete();
    addr = a; wdata = wd; mem_read = rd; mem_write = wr;
    n_stall = 0;
    rdata   = '0;
    for (int c = 0; c <= exp_stall; c++) begin
      @(negedge clk);
      check("stall_cycle", stall_o, (c < exp_stall));
      if (stall_o) n_stall++;
      if (c == exp_stall) begin
        rdata = data_o;
        if (rd && !wr) check("load_data", data_o, exp_data);
      end
    end
    guard = 0;
    while (stall_o && guard < 64) begin
      @(negedge clk);
      n_stall++;
      guard++;
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0;

    check("traffic_count", traffic.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < traffic.size(); i++) begin
      check("traffic_dir", traffic[i].wr, exp_q[i].wr);
      check("traffic_addr", traffic[i].addr, exp_q[i].addr);
      if (exp_q[i].wr) check("writeback_line", traffic[i].data, exp_q[i].data);
    end
`ifdef DCACHE_STATS_EN
    check("hit_cnt", hit_cnt_o, m_hits);
    check("miss_cnt", miss_cnt_o, m_misses);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int          ns;
    logic [31:0] rd_d;
    logic [31:0] a;

    man_ack = 1'b0;
    rst = 1'b1;
    addr = '0; wdata = '0; mem_read = 1'b0; mem_write = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_stall", stall_o, 1'b0);
    check("rst_data", data_o, 32'h0);
    check("rst_mem_enable", mem_enable_o, 1'b0);
    check("rst_mem_write", mem_write_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 28'h0);
    check("rst_mem_data", mem_data_o, 128'h0);
    @(posedge clk);
    #1;

    // Clean miss at L=3.
    mem[28'h0000010] = {32'h4444, 32'h3333, 32'h2222, 32'h1111};
    access(32'h0000_0104, 1, 0, 0, 3, ns, rd_d);
    check("first_miss_stall", ns, 6);
    check("first_miss_data", rd_d, 32'h2222);
    check("first_miss_read_addr", traffic.size() > 0 ? traffic[0].addr : 28'hFFFFFFF, 28'h0000010);

    access(32'h0000_0104, 1, 0, 0, 3, ns, rd_d);
    check("repeat_hit_stall", ns, 0);
    check("repeat_hit_data", rd_d, 32'h2222);
`ifdef DCACHE_STATS_EN
    check("plan_hit_cnt", hit_cnt_o, 32'd1);
    check("plan_miss_cnt", miss_cnt_o, 32'd1);
`endif

    access(32'h0000_0108, 0, 1, 32'hDEAD_BEEF, 3, ns, rd_d);
    check("store_hit_stall", ns, 0);
    access(32'h0000_0108, 1, 0, 0, 3, ns, rd_d);
    check("store_readback", rd_d, 32'hDEAD_BEEF);
    check("store_readback_traffic", traffic.size(), 0);

    // Dirty miss: same index, new tag.
    access(32'h0000_0308, 1, 0, 0, 3, ns, rd_d);
    check("dirty_miss_stall", ns, 10);
    if (traffic.size() == 2) begin
      check("wb_addr_literal", traffic[0].addr, 28'h0000010);
      check("wb_word2_literal", traffic[0].data[95:64], 32'hDEAD_BEEF);
      check("alloc_addr_literal", traffic[1].addr, 28'h0000030);
    end else begin
      check("dirty_miss_txn_count", traffic.size(), 2);
    end

    // Read+write together is a store and dirties the line.
    access(32'h0000_030C, 1, 1, 32'h1234_5678, 2, ns, rd_d);
    check("both_hit_stall", ns, 0);
    access(32'h0000_010C, 1, 0, 0, 2, ns, rd_d);
    check("both_dirty_stall", ns, 8);
    if (traffic.size() == 2) begin
      check("both_wb_dir", traffic[0].wr, 1'b1);
      check("both_wb_word3", traffic[0].data[127:96], 32'h1234_5678);
    end else begin
      check("both_txn_count", traffic.size(), 2);
    end

    // Reset in the middle of ALLOCATE; the late ack must be ignored.
    resp_on = 0;
    addr = 32'h0000_0A50; mem_read = 1'b1;
    @(negedge clk);
    check("rst_mid_stall", stall_o, 1'b1);
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_enable_up", mem_enable_o, 1'b1);
    check("rst_mid_alloc_addr", mem_addr_o, 28'h00000A5);
    check("rst_mid_alloc_dir", mem_write_o, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0; man_ack = 1'b1;
    @(negedge clk);
    check("rst_mid_enable_down", mem_enable_o, 1'b0);
    check("rst_mid_stall_down", stall_o, 1'b0);
    @(posedge clk);
    #1;
    man_ack = 1'b0;
    @(negedge clk);
    check("late_ack_enable", mem_enable_o, 1'b0);
    check("late_ack_stall", stall_o, 1'b0);
    @(posedge clk);
    #1;
    resp_on = 1;
    model_reset();
    access(32'h0000_0A50, 1, 0, 0, 3, ns, rd_d);
    check("post_rst_remiss_stall", ns, 6);
    // Previously valid line is gone too.
    access(32'h0000_0308, 1, 0, 0, 1, ns, rd_d);
    check("post_rst_invalid_stall", ns, 4);

    // Random traffic over a small set of tags and indices.
    for (int n = 0; n < 300; n++) begin
      int op;
      a = {23'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      op = $urandom_range(0, 9);
      access(a, (op < 5) || (op == 8), (op >= 5) && (op != 9), $urandom,
             $urandom_range(1, 4), ns, rd_d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
